// File: rtl/digi_pkg.sv
// -----------------------------------------------------------------------------
// digi_pkg
// Shared definitions for the ADC-to-DBUFF writer and the downstream pump.
//   DBUFF_ADDR_W : DBUFF byte-address width (buffer depth 2^DBUFF_ADDR_W)
//   BLOCK_BYTES  : bytes per block (power of two)
//   HDR_BYTES    : sequence-header bytes at the start of each block
//   state_t      : writer FSM encoding, one-hot
//   hdr_byte()   : selects one byte of the 32-bit block number, LSB first
// -----------------------------------------------------------------------------
package digi_pkg;

    localparam int DBUFF_ADDR_W = 15;
    localparam int BLOCK_BYTES  = 512;
    localparam int HDR_BYTES    = 4;

    // One-hot; any illegal pattern is steered back to ST_IDLE by the FSM default.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_HEADER = 4'b0010,
        ST_DATA   = 4'b0100,
        ST_OVR    = 4'b1000
    } state_t;

    function automatic logic [7:0] hdr_byte(input logic [31:0] blk, input logic [1:0] idx);
        logic [31:0] shifted;
        shifted = blk >> {idx, 3'b000};
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/adc_to_digi_buff_if.sv
// -----------------------------------------------------------------------------
// adc_to_digi_buff_if
// Bundles the sample stream, the pump feedback and the DBUFF write port.
//   master : ADC front end / pump side (drives ENA, SAMPLE_*, BLOCKS_PUMPED)
//   slave  : adc_to_digi_buff (drives the DBUFF write port and status)
//
// Handshake: SAMPLE_VALID is a one-cycle strobe qualifying SAMPLE_DATA on the
// same rising CLK edge. There is no ready/backpressure; a sample offered while
// the skid FIFO is full is lost and recorded in the sticky DROPPED flag.
// WENA_DBUFF qualifies WADDR_DBUFF/WDATA_DBUFF; the RAM captures the write on
// the next rising edge of WCLK_DBUFF.
// -----------------------------------------------------------------------------
interface adc_to_digi_buff_if #(
    parameter int ADDR_W = digi_pkg::DBUFF_ADDR_W
);
    import digi_pkg::*;

    logic              ENA;
    logic [7:0]        SAMPLE_DATA;
    logic              SAMPLE_VALID;
    logic [31:0]       BLOCKS_PUMPED;
    logic [ADDR_W-1:0] WADDR_DBUFF;
    logic [7:0]        WDATA_DBUFF;
    logic              WENA_DBUFF;
    logic              WCLK_DBUFF;
    logic [31:0]       BLOCKS_DIGITIZED;
    logic              ACQ_ACTIVE;
    logic              OVERRUN;
    logic              DROPPED;
    state_t            STATE_DBG;

    modport master (
        output ENA, SAMPLE_DATA, SAMPLE_VALID, BLOCKS_PUMPED,
        input  WADDR_DBUFF, WDATA_DBUFF, WENA_DBUFF, WCLK_DBUFF,
        input  BLOCKS_DIGITIZED, ACQ_ACTIVE, OVERRUN, DROPPED, STATE_DBG
    );

    modport slave (
        input  ENA, SAMPLE_DATA, SAMPLE_VALID, BLOCKS_PUMPED,
        output WADDR_DBUFF, WDATA_DBUFF, WENA_DBUFF, WCLK_DBUFF,
        output BLOCKS_DIGITIZED, ACQ_ACTIVE, OVERRUN, DROPPED, STATE_DBG
    );

endinterface

// File: rtl/sample_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
// Synchronous first-word-fall-through FIFO, DEPTH x 8, absorbing samples while
// the writer is busy emitting the block header.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request (ignored when full unless a pop happens too)
//   pop, dout  : read request; dout shows the head entry whenever !empty
//   flush      : empties the FIFO, overriding push and pop
//   full/empty : occupancy status
// -----------------------------------------------------------------------------
module sample_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = 1'b0;
        do_push  = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            do_pop  = pop && !empty;
            // A pop in the same cycle frees the slot, so a full FIFO still accepts.
            do_push = push && (!full || do_pop);
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/adc_to_digi_buff.sv
// -----------------------------------------------------------------------------
// adc_to_digi_buff
// Writes the ADC byte stream into the circular DBUFF in BLOCK_BYTES blocks,
// each starting with a HDR_BYTES little-endian copy of the block number, and
// publishes the completed-block count to the pump.
//   CLK : system clock (posedge)
//   RST : asynchronous active-low reset
//   bus : adc_to_digi_buff_if.slave
//         in : ENA, SAMPLE_DATA, SAMPLE_VALID, BLOCKS_PUMPED
//         out: WADDR/WDATA/WENA/WCLK_DBUFF, BLOCKS_DIGITIZED, ACQ_ACTIVE,
//              OVERRUN, DROPPED, STATE_DBG
// -----------------------------------------------------------------------------
module adc_to_digi_buff #(
    parameter int ADDR_W          = digi_pkg::DBUFF_ADDR_W,
    parameter int BLOCK_BYTES     = digi_pkg::BLOCK_BYTES,
    parameter int HDR_BYTES       = digi_pkg::HDR_BYTES,
    parameter int HEADROOM_BLOCKS = 1,
    parameter int FIFO_DEPTH      = 8
) (
    input logic              CLK,
    input logic              RST,
    adc_to_digi_buff_if.slave bus
);

    import digi_pkg::*;

    localparam int          BW       = $clog2(BLOCK_BYTES);
    localparam int          BLK_W    = ADDR_W - BW;
    localparam logic [31:0] FULL_LIM = 32'((1 << ADDR_W) / BLOCK_BYTES - HEADROOM_BLOCKS);
    localparam logic [BW-1:0] HDR_LAST = BW'(HDR_BYTES - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLOCK_BYTES - 1);

    state_t            state_q, state_d;
    logic [BW-1:0]     byte_cnt_q, byte_cnt_d;
    logic [31:0]       blk_ptr_q, blk_ptr_d;
    logic              commit_q, commit_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              wena_q, wena_d;
    logic              overrun_q, overrun_d;
    logic              dropped_q, dropped_d;

    logic        fifo_push, fifo_pop, fifo_flush;
    logic        fifo_full, fifo_empty;
    logic [7:0]  fifo_dout;
    logic [31:0] cur_blk;
    logic        full_now, full_next;
    logic        acq;

    assign acq       = (state_q == ST_HEADER) || (state_q == ST_DATA);
    assign fifo_push = bus.SAMPLE_VALID && acq;

    // The final byte's commit lands one cycle after it is decided, together
    // with the RAM capturing that write. Until then cur_blk already reflects
    // the committed block so the next header and full check use the new number.
    assign cur_blk   = blk_ptr_q + {31'b0, commit_q};
    assign full_now  = (cur_blk - bus.BLOCKS_PUMPED) >= FULL_LIM;
    assign full_next = (cur_blk + 32'd1 - bus.BLOCKS_PUMPED) >= FULL_LIM;

    sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (CLK),
        .rst_n (RST),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (bus.SAMPLE_DATA),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        blk_ptr_d  = cur_blk;
        commit_d   = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        wena_d     = 1'b0;
        dropped_d  = dropped_q;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        case (state_q)
            ST_IDLE: begin
                byte_cnt_d = '0;
                fifo_flush = 1'b1;
                if (bus.ENA) begin
                    if (full_now) begin
                        state_d = ST_OVR;
                    end else begin
                        state_d   = ST_HEADER;
                        dropped_d = 1'b0;
                    end
                end
            end
            ST_HEADER: begin
                if (!bus.ENA) begin
                    // Abort: the partial block is rewritten from its header later.
                    state_d    = ST_IDLE;
                    byte_cnt_d = '0;
                    fifo_flush = 1'b1;
                end else begin
                    wena_d     = 1'b1;
                    waddr_d    = {cur_blk[BLK_W-1:0], byte_cnt_q};
                    wdata_d    = hdr_byte(cur_blk, byte_cnt_q[1:0]);
                    byte_cnt_d = byte_cnt_q + BW'(1);
                    if (byte_cnt_q == HDR_LAST) state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!bus.ENA) begin
                    state_d    = ST_IDLE;
                    byte_cnt_d = '0;
                    fifo_flush = 1'b1;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    wena_d   = 1'b1;
                    waddr_d  = {cur_blk[BLK_W-1:0], byte_cnt_q};
                    wdata_d  = fifo_dout;
                    if (byte_cnt_q == BLK_LAST) begin
                        byte_cnt_d = '0;
                        commit_d   = 1'b1;
                        state_d    = full_next ? ST_OVR : ST_HEADER;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BW'(1);
                    end
                end
            end
            ST_OVR: begin
                byte_cnt_d = '0;
                fifo_flush = 1'b1;
                if (!bus.ENA) state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                byte_cnt_d = '0;
                fifo_flush = 1'b1;
            end
        endcase

        // A sample is lost only when it cannot enter: full, no pop this cycle,
        // and not being discarded by a flush anyway.
        if (fifo_push && fifo_full && !fifo_pop && !fifo_flush) dropped_d = 1'b1;

        // Registered like WENA so OVERRUN rises with the first idle write cycle
        // and falls in the same cycle the FSM leaves OVR.
        overrun_d = (state_q == ST_OVR) && bus.ENA;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= '0;
            blk_ptr_q  <= '0;
            commit_q   <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            wena_q     <= 1'b0;
            overrun_q  <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            blk_ptr_q  <= blk_ptr_d;
            commit_q   <= commit_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            wena_q     <= wena_d;
            overrun_q  <= overrun_d;
            dropped_q  <= dropped_d;
        end
    end

    assign bus.WADDR_DBUFF      = waddr_q;
    assign bus.WDATA_DBUFF      = wdata_q;
    assign bus.WENA_DBUFF       = wena_q;
    assign bus.WCLK_DBUFF       = CLK;
    assign bus.BLOCKS_DIGITIZED = blk_ptr_q;
    assign bus.ACQ_ACTIVE       = acq;
    assign bus.OVERRUN          = overrun_q;
    assign bus.DROPPED          = dropped_q;
    assign bus.STATE_DBG        = state_q;

endmodule

// File: tb/tb_adc_to_digi_buff.sv
// -----------------------------------------------------------------------------
// tb_adc_to_digi_buff
// Directed bench for adc_to_digi_buff: reset, nominal block, wrap, overrun,
// FIFO overflow and mid-block abort. A negedge monitor logs every DBUFF write
// and keeps a byte-image of the buffer; expected writes go through exp_q.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adc_to_digi_buff;
    import digi_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adc_to_digi_buff_if dif ();

    adc_to_digi_buff dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (dif)
    );

    // ---------------- counters / scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [22:0] exp_q[$];
    logic [22:0] wr_log[$];
    int          rd_idx   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic [7:0]  mem_model [0:32767];
    int          wr511_cyc   = 0;
    int          dig_chg_cyc = 0;
    logic [31:0] dig_prev    = '0;
    int          ovr_cnt     = 0;

    always @(negedge clk) begin
        if (dif.WENA_DBUFF === 1'b1) begin
            wr_log.push_back({dif.WADDR_DBUFF, dif.WDATA_DBUFF});
            mem_model[dif.WADDR_DBUFF] = dif.WDATA_DBUFF;
            if (dif.WADDR_DBUFF == 15'd511) wr511_cyc = cyc;
        end
        if (dif.BLOCKS_DIGITIZED !== dig_prev) begin
            dig_chg_cyc = cyc;
            dig_prev    = dif.BLOCKS_DIGITIZED;
        end
        if (dif.OVERRUN === 1'b1) ovr_cnt++;
    end

    // ---------------- sample / pump driver ----------------
    int          gen_mode   = 0;   // 0 off, 1 every 2nd cycle, 2 every cycle
    int          gen_left   = 0;
    int          gen_cnt    = 0;
    logic [7:0]  sample_val = '0;
    bit          track_en   = 0;
    logic [31:0] pumped_val = '0;

    initial begin
        dif.SAMPLE_VALID  = 1'b0;
        dif.SAMPLE_DATA   = '0;
        dif.BLOCKS_PUMPED = '0;
        forever begin
            @(posedge clk);
            #2;
            if (track_en)
                dif.BLOCKS_PUMPED = (dif.BLOCKS_DIGITIZED == 0) ? 32'd0 : dif.BLOCKS_DIGITIZED - 32'd1;
            else
                dif.BLOCKS_PUMPED = pumped_val;
            if (gen_mode != 0 && gen_left > 0 && (gen_mode == 2 || (gen_cnt % 2) == 0)) begin
                dif.SAMPLE_VALID = 1'b1;
                dif.SAMPLE_DATA  = sample_val;
                sample_val       = sample_val + 8'd1;
                gen_left--;
            end else begin
                dif.SAMPLE_VALID = 1'b0;
            end
            gen_cnt++;
        end
    end

    // ---------------- helper tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_ena(input logic v);
        @(posedge clk);
        #1 dif.ENA = v;
    endtask

    task automatic start_gen(input int mode, input int count);
        gen_cnt  = 0;
        gen_left = count;
        gen_mode = mode;
    endtask

    task automatic do_reset();
        dif.ENA    = 1'b0;
        gen_mode   = 0;
        track_en   = 0;
        pumped_val = '0;
        sample_val = '0;
        rst_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        rd_idx = wr_log.size();
    endtask

    task automatic wait_acq(input int budget);
        for (int i = 0; i < budget && dif.ACQ_ACTIVE !== 1'b1; i++) tick();
    endtask

    task automatic wait_dig(input logic [31:0] target, input int budget);
        for (int i = 0; i < budget && dif.BLOCKS_DIGITIZED !== target; i++) tick();
    endtask

    task automatic wait_log(input int n, input int budget);
        for (int i = 0; i < budget && wr_log.size() < n; i++) tick();
    endtask

    task automatic push_hdr(input int base_addr, input logic [31:0] blk);
        logic [31:0] b;
        b = blk;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({15'(base_addr + i), b[7:0]});
            b = b >> 8;
        end
    endtask

    task automatic sb_drain(input string tag);
        logic [22:0] e, o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd_idx < wr_log.size()) begin
                o = wr_log[rd_idx];
                rd_idx++;
            end else begin
                o = '1;
            end
            check(tag, 32'(o), 32'(e));
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int          bad;
        int          base;
        logic [22:0] ent, prv;

        dif.ENA = 1'b0;

        // 1. Reset held: activity on the inputs must not reach the outputs.
        rst_n = 1'b0;
        start_gen(2, 1000);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            drive_ena(i[0]);
            tick();
            if (dif.WENA_DBUFF !== 1'b0 || dif.WADDR_DBUFF !== '0 || dif.WDATA_DBUFF !== '0 ||
                dif.BLOCKS_DIGITIZED !== '0 || dif.ACQ_ACTIVE !== 1'b0 ||
                dif.OVERRUN !== 1'b0 || dif.DROPPED !== 1'b0)
                bad++;
        end
        check("t1_rst_any_nonzero", 32'(bad), 32'd0);
        check("t1_waddr", 32'(dif.WADDR_DBUFF), 32'd0);
        check("t1_wdata", 32'(dif.WDATA_DBUFF), 32'd0);
        check("t1_dig", dif.BLOCKS_DIGITIZED, 32'd0);
        check("t1_overrun", 32'(dif.OVERRUN), 32'd0);
        check("t1_dropped", 32'(dif.DROPPED), 32'd0);
        check("t1_state", 32'(dif.STATE_DBG), 32'(ST_IDLE));
        check("t1_no_writes", 32'(wr_log.size()), 32'd0);

        // 2. Nominal block, one sample every two cycles.
        do_reset();
        drive_ena(1'b1);
        wait_acq(10);
        check("t2_acq", 32'(dif.ACQ_ACTIVE), 32'd1);
        start_gen(1, 508);
        wait_dig(32'd1, 3000);
        check("t2_dig", dif.BLOCKS_DIGITIZED, 32'd1);
        check("t2_dig_latency", 32'(dig_chg_cyc - wr511_cyc), 32'd1);
        wait_log(rd_idx + 516, 50);
        push_hdr(0, 32'd0);
        for (int k = 0; k < 508; k++) exp_q.push_back({15'(4 + k), 8'(k)});
        push_hdr(512, 32'd1);
        sb_drain("t2_write");
        check("t2_overrun", 32'(dif.OVERRUN), 32'd0);
        check("t2_dropped", 32'(dif.DROPPED), 32'd0);

        // 3. Wrap: pump trails by one block, 65 blocks.
        do_reset();
        base     = ovr_cnt;
        track_en = 1;
        drive_ena(1'b1);
        wait_acq(10);
        start_gen(2, 1000000);
        wait_dig(32'd65, 40000);
        check("t3_dig", dif.BLOCKS_DIGITIZED, 32'd65);
        check("t3_hdr0", 32'(mem_model[0]), 32'h40);
        check("t3_hdr1", 32'(mem_model[1]), 32'h00);
        check("t3_hdr2", 32'(mem_model[2]), 32'h00);
        check("t3_hdr3", 32'(mem_model[3]), 32'h00);
        check("t3_no_overrun", 32'(ovr_cnt - base), 32'd0);

        // 4. Overrun with the pump stalled at 0.
        do_reset();
        drive_ena(1'b1);
        wait_acq(10);
        start_gen(2, 1000000);
        for (int i = 0; i < 40000 && dif.OVERRUN !== 1'b1; i++) tick();
        check("t4_overrun", 32'(dif.OVERRUN), 32'd1);
        check("t4_dig", dif.BLOCKS_DIGITIZED, 32'd63);
        check("t4_wena", 32'(dif.WENA_DBUFF), 32'd0);
        ent = wr_log[wr_log.size() - 1];
        check("t4_last_addr", 32'(ent[22:8]), 32'd32255);
        base       = wr_log.size();
        pumped_val = 32'd10;
        repeat (20) tick();
        check("t4_hold_overrun", 32'(dif.OVERRUN), 32'd1);
        check("t4_hold_nowrite", 32'(wr_log.size() - base), 32'd0);
        drive_ena(1'b0);
        tick();
        tick();
        check("t4_overrun_clr", 32'(dif.OVERRUN), 32'd0);
        check("t4_state_idle", 32'(dif.STATE_DBG), 32'(ST_IDLE));
        rd_idx = wr_log.size();
        drive_ena(1'b1);
        wait_log(rd_idx + 4, 20);
        push_hdr(63 * 512, 32'd63);
        sb_drain("t4_resume");

        // 5. FIFO overflow: a sample every cycle across several headers.
        do_reset();
        drive_ena(1'b1);
        wait_acq(10);
        base = wr_log.size();
        start_gen(2, 1100);
        repeat (1200) tick();
        check("t5_dropped", 32'(dif.DROPPED), 32'd1);
        check("t5_dig", dif.BLOCKS_DIGITIZED, 32'd2);
        bad = 0;
        prv = wr_log[base];
        for (int i = base + 1; i < wr_log.size(); i++) begin
            ent = wr_log[i];
            if (ent[22:8] != prv[22:8] + 15'd1) bad++;
            prv = ent;
        end
        check("t5_first_addr", 32'(wr_log[base] >> 8), 32'd0);
        check("t5_addr_gaps", 32'(bad), 32'd0);
        check("t5_addr511", 32'(wr_log[base + 511] >> 8), 32'd511);
        check("t5_next_hdr", 32'(wr_log[base + 512]), 32'({15'd512, 8'h01}));
        drive_ena(1'b0);
        tick();
        tick();
        check("t5_dropped_sticky", 32'(dif.DROPPED), 32'd1);
        drive_ena(1'b1);
        tick();
        tick();
        check("t5_dropped_clr", 32'(dif.DROPPED), 32'd0);

        // 6. Abort after 200 sample writes in block 2, then restart.
        do_reset();
        drive_ena(1'b1);
        wait_acq(10);
        start_gen(1, 1000000);
        wait_dig(32'd2, 3000);
        check("t6_dig_reach", dif.BLOCKS_DIGITIZED, 32'd2);
        for (int i = 0; i < 600 && !(dif.WENA_DBUFF === 1'b1 && dif.WADDR_DBUFF == 15'd1227); i++) tick();
        check("t6_reach_1227", 32'(dif.WADDR_DBUFF), 32'd1227);
        drive_ena(1'b0);
        tick();
        tick();
        check("t6_wena_off", 32'(dif.WENA_DBUFF), 32'd0);
        check("t6_acq_off", 32'(dif.ACQ_ACTIVE), 32'd0);
        check("t6_dig_keep", dif.BLOCKS_DIGITIZED, 32'd2);
        base = wr_log.size();
        repeat (20) tick();
        check("t6_idle_nowrite", 32'(wr_log.size() - base), 32'd0);
        check("t6_idle_nodrop", 32'(dif.DROPPED), 32'd0);
        gen_mode = 0;
        rd_idx   = wr_log.size();
        drive_ena(1'b1);
        wait_log(rd_idx + 4, 20);
        push_hdr(1024, 32'd2);
        sb_drain("t6_restart");
        check("t6_dig_after", dif.BLOCKS_DIGITIZED, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
